// File: rtl/mmult_pkg.sv
// mmult_pkg -- shared definitions for the mmult_gen matrix multiplier.
//   state_t / ST_* : FSM encoding (IDLE, COMPUTE, DONE)
//   calc_cw()      : width of a C element that holds an N-term dot product
//                    of DW-bit operands without overflow
package mmult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COMPUTE = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

    // Each product needs 2*DW bits. Summing N of them needs clog2(N) more.
    function automatic int calc_cw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mmult_gen_if.sv
// mmult_gen_if -- request/result bundle for mmult_gen.
//   start, signed_mode, A_mat, B_mat : request (master -> slave)
//   busy, valid, C_mat               : status/result (slave -> master)
// Matrices are row-major. Element (i,j) is the (i*N+j)-th field counted from the MSB.
interface mmult_gen_if
    import mmult_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8
);
    localparam int CW = calc_cw(N, DW);

    logic                  start;
    logic                  signed_mode;
    logic [N*N*DW-1:0]     A_mat;
    logic [N*N*DW-1:0]     B_mat;
    logic                  busy;
    logic                  valid;
    logic [N*N*CW-1:0]     C_mat;

    modport master (
        output start, signed_mode, A_mat, B_mat,
        input  busy, valid, C_mat
    );

    modport slave (
        input  start, signed_mode, A_mat, B_mat,
        output busy, valid, C_mat
    );
endinterface

// File: rtl/mmult_dot.sv
// mmult_dot -- combinational N-term dot product.
//   a_row, b_col : N operands of DW bits each. Index t pairs a_row[t] with b_col[t].
//   signed_mode  : 1 = sign-extend operands, 0 = zero-extend
//   dot          : sum of products, CW bits
// The operands are extended to CW bits before the multiply. The products and
// the sum are therefore exact modulo 2^CW. CW is sized so that the true result
// always fits, so the value is exact in either mode.
module mmult_dot
    import mmult_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int CW = calc_cw(N, DW)
)(
    input  logic [N-1:0][DW-1:0] a_row,
    input  logic [N-1:0][DW-1:0] b_col,
    input  logic                 signed_mode,
    output logic [CW-1:0]        dot
);
    logic [CW-1:0] ea;
    logic [CW-1:0] eb;

    always_comb begin
        dot = '0;
        ea  = '0;
        eb  = '0;
        for (int t = 0; t < N; t++) begin
            ea  = signed_mode ? {{(CW-DW){a_row[t][DW-1]}}, a_row[t]}
                              : {{(CW-DW){1'b0}},           a_row[t]};
            eb  = signed_mode ? {{(CW-DW){b_col[t][DW-1]}}, b_col[t]}
                              : {{(CW-DW){1'b0}},           b_col[t]};
            dot = dot + ea * eb;
        end
    end

endmodule

// File: rtl/mmult_gen.sv
// mmult_gen -- N x N matrix multiplier, C = A x B, one column of C per cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mmult_gen_if slave port
//             start/signed_mode/A_mat/B_mat are sampled when the block is in IDLE or DONE.
//             busy is high during the N COMPUTE cycles.
//             valid/C_mat hold the finished result until the next accepted start.
// Operation: on an accepted start the operands are latched and C is cleared.
// In COMPUTE cycle k, N dot-product units form column k of C: row i of A
// multiplied by column k of B. After column N-1 is written, the block enters
// DONE and raises valid.
module mmult_gen
    import mmult_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8
)(
    input  logic       clk,
    input  logic       reset,
    mmult_gen_if.slave bus
);
    localparam int CW = calc_cw(N, DW);
    localparam int KW = $clog2(N);
    localparam int NE = N * N;

    state_t              state;
    logic [KW-1:0]       k;
    logic [NE*DW-1:0]    a_q;
    logic [NE*DW-1:0]    b_q;
    logic                sm_q;
    logic [NE*CW-1:0]    c_q;
    logic                valid_q;

    logic [N-1:0][N-1:0][DW-1:0] a_rows;
    logic [N-1:0][DW-1:0]        b_col;
    logic [N-1:0][CW-1:0]        dot;

    // Operand routing. The rows of A are fixed. The column of B follows k.
    always_comb begin
        a_rows = '0;
        b_col  = '0;
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < N; t++) begin
                a_rows[i][t] = a_q[(NE-1-(i*N+t))*DW +: DW];
            end
        end
        for (int t = 0; t < N; t++) begin
            b_col[t] = b_q[(NE-1-(t*N+int'(k)))*DW +: DW];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_dot
        mmult_dot #(
            .N  (N),
            .DW (DW),
            .CW (CW)
        ) u_dot (
            .a_row       (a_rows[i]),
            .b_col       (b_col),
            .signed_mode (sm_q),
            .dot         (dot[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.A_mat;
                        b_q     <= bus.B_mat;
                        sm_q    <= bus.signed_mode;
                        c_q     <= '0;
                        valid_q <= 1'b0;
                        k       <= '0;
                        state   <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    // Only column k is written, so earlier columns stay stable.
                    for (int i = 0; i < N; i++) begin
                        c_q[(NE-1-(i*N+int'(k)))*CW +: CW] <= dot[i];
                    end
                    if (k == KW'(N-1)) begin
                        k       <= '0;
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == ST_COMPUTE);
    assign bus.valid = valid_q;
    assign bus.C_mat = c_q;

endmodule

// File: tb/tb_mmult_gen.sv
// tb_mmult_gen -- directed, table-driven bench for mmult_gen (N=3, DW=8, CW=18).
module tb_mmult_gen;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int CW = 18;
    localparam int NE = N * N;
    localparam int NV = 8;

    typedef struct {
        string name;
        logic  sm;
        int    a[9];
        int    b[9];
        int    c[9];
    } vec_t;

    logic clk;
    logic reset;
    vec_t vecs[NV];
    int   nvec;
    int   errs;

    mmult_gen_if #(.N(N), .DW(DW)) bus ();

    mmult_gen #(.N(N), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [NE*CW-1:0] got, input logic [NE*CW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Expected C with only columns < ncols filled in. The other columns are zero.
    function automatic logic [NE*CW-1:0] exp_c(input int idx, input int ncols);
        logic [NE*CW-1:0] r;
        r = '0;
        for (int e = 0; e < NE; e++) begin
            if ((e % N) < ncols)
                r[(NE-1-e)*CW +: CW] = CW'(vecs[idx].c[e]);
        end
        return r;
    endfunction

    task automatic drive_garbage(input logic st);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        bus.A_mat       = r[NE*DW-1:0];
        r = {$urandom(), $urandom(), $urandom()};
        bus.B_mat       = r[NE*DW-1:0];
        bus.signed_mode = ~bus.signed_mode;
        bus.start       = st;
    endtask

    // Call at a negedge. Drives the start request and tracks busy/valid/C
    // through every COMPUTE edge. Returns at a negedge with start low.
    // At edge number repulse, a start with garbage data is asserted.
    task automatic run_vec(input int idx, input int repulse);
        string nm;
        nm = vecs[idx].name;
        for (int e = 0; e < NE; e++) begin
            bus.A_mat[(NE-1-e)*DW +: DW] = DW'(vecs[idx].a[e]);
            bus.B_mat[(NE-1-e)*DW +: DW] = DW'(vecs[idx].b[e]);
        end
        bus.signed_mode = vecs[idx].sm;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        chk({nm, "/busy@0"},  (NE*CW)'(bus.busy),  (NE*CW)'(1'b1));
        chk({nm, "/valid@0"}, (NE*CW)'(bus.valid), (NE*CW)'(1'b0));
        chk({nm, "/C@0"},     bus.C_mat,           exp_c(idx, 0));
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            drive_garbage(c == repulse);
            @(posedge clk); #1;
            chk($sformatf("%s/busy@%0d", nm, c),  (NE*CW)'(bus.busy),  (NE*CW)'(c < N));
            chk($sformatf("%s/valid@%0d", nm, c), (NE*CW)'(bus.valid), (NE*CW)'(c == N));
            chk($sformatf("%s/C@%0d", nm, c),     bus.C_mat,           exp_c(idx, c));
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic hold_chk(input int idx);
        repeat (2) @(posedge clk);
        #1;
        chk({vecs[idx].name, "/hold_valid"}, (NE*CW)'(bus.valid), (NE*CW)'(1'b1));
        chk({vecs[idx].name, "/hold_busy"},  (NE*CW)'(bus.busy),  (NE*CW)'(1'b0));
        chk({vecs[idx].name, "/hold_C"},     bus.C_mat,           exp_c(idx, N));
        @(negedge clk);
    endtask

    initial begin
        nvec = 0;
        errs = 0;

        vecs[0].name = "ident_x_1to9"; vecs[0].sm = 1'b0;
        vecs[0].a = '{1,0,0, 0,1,0, 0,0,1};
        vecs[0].b = '{1,2,3, 4,5,6, 7,8,9};
        vecs[0].c = '{1,2,3, 4,5,6, 7,8,9};

        vecs[1].name = "all255_u"; vecs[1].sm = 1'b0;
        vecs[1].a = '{255,255,255, 255,255,255, 255,255,255};
        vecs[1].b = '{255,255,255, 255,255,255, 255,255,255};
        vecs[1].c = '{195075,195075,195075, 195075,195075,195075, 195075,195075,195075};

        vecs[2].name = "all80_s"; vecs[2].sm = 1'b1;
        vecs[2].a = '{128,128,128, 128,128,128, 128,128,128};
        vecs[2].b = '{128,128,128, 128,128,128, 128,128,128};
        vecs[2].c = '{49152,49152,49152, 49152,49152,49152, 49152,49152,49152};

        vecs[3].name = "all80_u"; vecs[3].sm = 1'b0;
        vecs[3].a = '{128,128,128, 128,128,128, 128,128,128};
        vecs[3].b = '{128,128,128, 128,128,128, 128,128,128};
        vecs[3].c = '{49152,49152,49152, 49152,49152,49152, 49152,49152,49152};

        vecs[4].name = "m1_x_1to9_s"; vecs[4].sm = 1'b1;
        vecs[4].a = '{255,255,255, 255,255,255, 255,255,255};
        vecs[4].b = '{1,2,3, 4,5,6, 7,8,9};
        vecs[4].c = '{-12,-15,-18, -12,-15,-18, -12,-15,-18};

        vecs[5].name = "ff_x_1to9_u"; vecs[5].sm = 1'b0;
        vecs[5].a = '{255,255,255, 255,255,255, 255,255,255};
        vecs[5].b = '{1,2,3, 4,5,6, 7,8,9};
        vecs[5].c = '{3060,3825,4590, 3060,3825,4590, 3060,3825,4590};

        vecs[6].name = "1to9_x_9to1"; vecs[6].sm = 1'b0;
        vecs[6].a = '{1,2,3, 4,5,6, 7,8,9};
        vecs[6].b = '{9,8,7, 6,5,4, 3,2,1};
        vecs[6].c = '{30,24,18, 84,69,54, 138,114,90};

        vecs[7].name = "mixed_x_ident_s"; vecs[7].sm = 1'b1;
        vecs[7].a = '{-1,2,-3, 4,-5,6, -7,8,-9};
        vecs[7].b = '{1,0,0, 0,1,0, 0,0,1};
        vecs[7].c = '{-1,2,-3, 4,-5,6, -7,8,-9};

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A_mat       = '0;
        bus.B_mat       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/busy",  (NE*CW)'(bus.busy),  '0);
        chk("reset/valid", (NE*CW)'(bus.valid), '0);
        chk("reset/C",     bus.C_mat,           '0);

        // The start arrives at the first edge after reset is released.
        // Some runs are back-to-back and some pause in DONE.
        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            run_vec(i, (i == 3) ? 2 : ((i == 5) ? 1 : -1));
            if (i % 2 == 1) hold_chk(i);
        end

        // Abort mid-COMPUTE. Reset is asserted while k=1, after column 0 was written.
        run_vec(0, -1);
        for (int e = 0; e < NE; e++) begin
            bus.A_mat[(NE-1-e)*DW +: DW] = DW'(vecs[6].a[e]);
            bus.B_mat[(NE-1-e)*DW +: DW] = DW'(vecs[6].b[e]);
        end
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("abort/pre_C", bus.C_mat, exp_c(6, 1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort/valid", (NE*CW)'(bus.valid), '0);
        chk("abort/busy",  (NE*CW)'(bus.busy),  '0);
        chk("abort/C",     bus.C_mat,           '0);
        @(posedge clk); #1;
        chk("abort/held_valid", (NE*CW)'(bus.valid), '0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(7, -1);
        hold_chk(7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
